mskstate_scan_seq: RTL and testbench

MSKSTATE_SCAN_SEQ -- requirements
Module: mskstate_scan_seq

---
 rtl/mskstate_scan_seq_pkg.sv | 15 +
 rtl/mskstate_beat_cnt.sv | 38 +++
 rtl/mskstate_scan_seq.sv | 101 ++++++++++
 tb/tb_mskstate_scan_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mskstate_scan_seq_pkg.sv
// Shared definitions for the masked-state scan sequencer: FSM encoding and sizing constants.
package mskstate_scan_seq_pkg;

    localparam int NBYTES = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        UNLOAD = 3'd4
    } state_e;

endpackage

// File: rtl/mskstate_beat_cnt.sv
// Beat counter: counts enabled beats from 0 to nbytes-1 and wraps, with a synchronous clear.
module mskstate_beat_cnt
    import mskstate_scan_seq_pkg::*;
#(
    parameter int nbytes = NBYTES,
    parameter int CNT_W  = (nbytes > 1) ? $clog2(nbytes) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic wrap_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(nbytes - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mskstate_scan_seq.sv
// Sequencer that loads masked bytes into a scan chain, runs the round core, and unloads the result.
module mskstate_scan_seq
    import mskstate_scan_seq_pkg::*;
#(
    parameter int d      = 2,
    parameter int nbytes = NBYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_W*d-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_W*d-1:0]   out_data,
    output logic                  chain_scan_en,
    output logic                  chain_en,
    output logic [BYTE_W*d-1:0]   chain_in,
    input  logic [BYTE_W*d-1:0]   chain_tail,
    output logic                  core_start,
    input  logic                  core_en,
    input  logic                  core_done,
    output logic                  busy
);

    state_e state_q, state_d;
    logic   cnt_en;
    logic   cnt_wrap;

    mskstate_beat_cnt #(
        .nbytes (nbytes)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == START),
        .en_i   (cnt_en),
        .wrap_o (cnt_wrap)
    );

    // Masked shares only ever travel through wires and muxes; no lane mixing.
    assign out_data = chain_tail;

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        chain_scan_en = 1'b0;
        chain_en      = 1'b0;
        chain_in      = '0;
        core_start    = 1'b0;
        busy          = 1'b0;
        cnt_en        = 1'b0;
        if (!rst) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE, LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        chain_scan_en = 1'b1;
                        chain_en      = 1'b1;
                        chain_in      = in_data;
                        cnt_en        = 1'b1;
                        state_d       = cnt_wrap ? START : LOAD;
                    end
                end
                START: begin
                    core_start = 1'b1;
                    state_d    = RUN;
                end
                RUN: begin
                    chain_en = core_en;
                    if (core_done) begin
                        state_d = UNLOAD;
                    end
                end
                UNLOAD: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        chain_scan_en = 1'b1;
                        chain_en      = 1'b1;
                        cnt_en        = 1'b1;
                        if (cnt_wrap) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reset aborts to IDLE but leaves chain contents alone; the next load overwrites them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mskstate_scan_seq.sv
// Directed self-checking bench for mskstate_scan_seq with a behavioural masked scan chain.
module tb_mskstate_scan_seq;

    localparam int NB = 16;
    localparam int W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         chain_scan_en, chain_en, core_start, core_en, core_done, busy;
    logic [W-1:0] in_data, out_data, chain_in, chain_tail;
    logic [W-1:0] chain [NB];

    int vec_cnt = 0;
    int err_cnt = 0;

    mskstate_scan_seq #(.d(2), .nbytes(NB)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .chain_scan_en (chain_scan_en),
        .chain_en      (chain_en),
        .chain_in      (chain_in),
        .chain_tail    (chain_tail),
        .core_start    (core_start),
        .core_en       (core_en),
        .core_done     (core_done),
        .busy          (busy)
    );

    // Scan chain model: head at index 0, tail at NB-1; core-mode enables just hold contents.
    always_ff @(posedge clk) begin
        if (chain_en && chain_scan_en) begin
            chain[0] <= chain_in;
            for (int i = 1; i < NB; i++) chain[i] <= chain[i-1];
        end
    end
    assign chain_tail = chain[NB-1];

    function automatic logic [W-1:0] mk(input logic [7:0] b);
        logic [7:0] m;
        m = 8'($urandom_range(0, 255));
        return {m, b ^ m};
    endfunction

    function automatic logic [7:0] xl(input logic [W-1:0] x);
        return x[15:8] ^ x[7:0];
    endfunction

    task automatic idle_in();
        in_valid = 1'b0; out_ready = 1'b0; core_en = 1'b0; core_done = 1'b0; in_data = '0;
    endtask

    task automatic do_load(input logic [7:0] base);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = mk(base + 8'(i));
        end
    endtask

    // START cycle, n-1 RUN cycles, then core_done in the n-th cycle after core_start.
    task automatic do_core(input int n);
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        for (int i = 1; i < n; i++) @(negedge clk);
        @(negedge clk); core_done = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_in(); in_valid = 1'b1; in_data = 16'h1234;
        repeat (2) @(negedge clk);
        #2;
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vec_cnt++; if (chain_en !== 1'b0 || chain_scan_en !== 1'b0) begin err_cnt++; $display("FAIL rst_chain got en=%b scan=%b want 0 0", chain_en, chain_scan_en); end
        vec_cnt++; if (core_start !== 1'b0) begin err_cnt++; $display("FAIL rst_core_start got %b want 0", core_start); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        #2;
        vec_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL post_rst got in_ready=%b busy=%b want 1 0", in_ready, busy); end
    endtask

    task automatic test_basic();
        int loads = 0, starts = 0;
        logic [7:0] exp;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = mk(8'(i));
            #2;
            vec_cnt++; if (chain_en !== 1'b1 || chain_scan_en !== 1'b1 || chain_in !== in_data) begin
                err_cnt++; $display("FAIL basic_load%0d got en=%b scan=%b in=%h want 1 1 %h", i, chain_en, chain_scan_en, chain_in, in_data); end
            loads += int'(chain_en); starts += int'(core_start);
        end
        @(negedge clk); in_valid = 1'b0; in_data = '0;
        #2;
        vec_cnt++; if (core_start !== 1'b1 || in_ready !== 1'b0 || chain_en !== 1'b0) begin
            err_cnt++; $display("FAIL basic_start got start=%b in_ready=%b en=%b want 1 0 0", core_start, in_ready, chain_en); end
        starts += int'(core_start);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); core_en = 1'($urandom_range(0, 1));
            #2;
            vec_cnt++; if (chain_en !== core_en || chain_scan_en !== 1'b0 || out_valid !== 1'b0 || chain_in !== '0) begin
                err_cnt++; $display("FAIL basic_run%0d got en=%b scan=%b ov=%b in=%h want %b 0 0 0", c, chain_en, chain_scan_en, out_valid, chain_in, core_en); end
            starts += int'(core_start);
        end
        @(negedge clk); core_en = 1'b0; core_done = 1'b1;
        #2;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_done_ov got %b want 0", out_valid); end
        for (int k = 0; k < NB; k++) begin
            @(negedge clk); core_done = 1'b0; out_ready = 1'b1;
            #2;
            exp = 8'(k);
            vec_cnt++; if (out_valid !== 1'b1 || xl(out_data) !== exp || chain_en !== 1'b1) begin
                err_cnt++; $display("FAIL basic_out%0d got ov=%b byte=%h en=%b want 1 %h 1", k, out_valid, xl(out_data), chain_en, exp); end
            starts += int'(core_start);
        end
        @(negedge clk); idle_in();
        #2;
        vec_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_end got busy=%b in_ready=%b want 0 1", busy, in_ready); end
        vec_cnt++; if (loads !== 16) begin err_cnt++; $display("FAIL basic_load_count got %0d want 16", loads); end
        vec_cnt++; if (starts !== 1) begin err_cnt++; $display("FAIL basic_start_count got %0d want 1", starts); end
    endtask

    task automatic test_toggle();
        int acc = 0;
        logic [7:0] exp;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            in_valid  = (c % 2 == 0);
            in_data   = in_valid ? mk(8'h30 + 8'(c / 2)) : 16'hFFFF;
            core_done = ~in_valid;
            #2;
            vec_cnt++; if (chain_en !== in_valid || chain_in !== (in_valid ? in_data : 16'h0000) || core_start !== (c == 31)) begin
                err_cnt++; $display("FAIL tog_c%0d got en=%b in=%h start=%b want %b %h %b", c, chain_en, chain_in, core_start,
                                    in_valid, in_valid ? in_data : 16'h0000, c == 31); end
            acc += int'(chain_en);
        end
        vec_cnt++; if (acc !== 16) begin err_cnt++; $display("FAIL tog_shift_count got %0d want 16", acc); end
        @(negedge clk); core_done = 1'b0;
        @(negedge clk); core_done = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk); core_done = 1'b0; out_ready = 1'b1;
            #2;
            exp = 8'h30 + 8'(k);
            vec_cnt++; if (out_valid !== 1'b1 || xl(out_data) !== exp) begin
                err_cnt++; $display("FAIL tog_out%0d got ov=%b byte=%h want 1 %h", k, out_valid, xl(out_data), exp); end
        end
        @(negedge clk); idle_in();
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        logic [7:0]   exp;
        do_load(8'h20);
        do_core(3);
        for (int k = 0; k < NB; k++) begin
            if (k == 7) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk); out_ready = 1'b0; core_done = 1'b1;
                    #2;
                    if (s == 0) held = out_data;
                    vec_cnt++; if (out_valid !== 1'b1 || chain_en !== 1'b0 || out_data !== held || xl(out_data) !== 8'h27) begin
                        err_cnt++; $display("FAIL stall_s%0d got ov=%b en=%b data=%h want 1 0 byte 27 held %h", s, out_valid, chain_en, out_data, held); end
                end
            end
            @(negedge clk); core_done = 1'b0; out_ready = 1'b1;
            #2;
            exp = 8'h20 + 8'(k);
            vec_cnt++; if (out_valid !== 1'b1 || xl(out_data) !== exp || chain_en !== 1'b1) begin
                err_cnt++; $display("FAIL stall_out%0d got ov=%b byte=%h en=%b want 1 %h 1", k, out_valid, xl(out_data), chain_en, exp); end
        end
        @(negedge clk); idle_in();
        #2;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL stall_end_busy got %b want 0", busy); end
    endtask

    task automatic test_rst_mid();
        logic [7:0] exp;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = mk(8'h90 + 8'(i));
        end
        @(negedge clk); in_data = mk(8'h99); rst = 1'b1;
        #2;
        vec_cnt++; if (chain_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_during got en=%b in_ready=%b busy=%b want 0 0 0", chain_en, in_ready, busy); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        #2;
        vec_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1 || chain_en !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_after got busy=%b in_ready=%b en=%b want 0 1 0", busy, in_ready, chain_en); end
        do_load(8'h50);
        do_core(2);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk); core_done = 1'b0; out_ready = 1'b1;
            #2;
            exp = 8'h50 + 8'(k);
            vec_cnt++; if (out_valid !== 1'b1 || xl(out_data) !== exp) begin
                err_cnt++; $display("FAIL rstmid_out%0d got ov=%b byte=%h want 1 %h", k, out_valid, xl(out_data), exp); end
        end
        @(negedge clk); idle_in();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        do_load(8'h60);
        do_core(2);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk); core_done = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hA5A5;
            #2;
            exp = 8'h60 + 8'(k);
            vec_cnt++; if (in_ready !== 1'b0 || chain_in !== '0 || xl(out_data) !== exp) begin
                err_cnt++; $display("FAIL b2b_out%0d got in_ready=%b in=%h byte=%h want 0 0000 %h", k, in_ready, chain_in, xl(out_data), exp); end
        end
        @(negedge clk); out_ready = 1'b0; in_data = mk(8'h70);
        #2;
        vec_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0 || chain_en !== 1'b1 || chain_in !== in_data) begin
            err_cnt++; $display("FAIL b2b_accept got in_ready=%b busy=%b en=%b in=%h want 1 0 1 %h", in_ready, busy, chain_en, chain_in, in_data); end
        for (int i = 1; i < NB; i++) begin
            @(negedge clk); in_data = mk(8'h70 + 8'(i));
        end
        do_core(2);
        for (int k = 0; k < NB; k++) begin
            @(negedge clk); core_done = 1'b0; out_ready = 1'b1;
            #2;
            exp = 8'h70 + 8'(k);
            vec_cnt++; if (out_valid !== 1'b1 || xl(out_data) !== exp) begin
                err_cnt++; $display("FAIL b2b_second%0d got ov=%b byte=%h want 1 %h", k, out_valid, xl(out_data), exp); end
        end
        @(negedge clk); idle_in();
        #2;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_end_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
